fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the 8-bit core. It sits directly upstream of the program-counter register and drives that register's `latch`/`inc`/`data` controls. It reads one- or two-byte instructions from instruction memory over a req/ack handshake and hands each complete instruction to decode over a valid/ready interface. Branch redirects from execute enter here and are applied to the PC.

## Interface
Parameters:
- `LONG_BIT`, default 7: opcode bit that marks a two-byte instruction (opcode + operand).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `pc_value`  in  8  current PC (program-counter register output)
- `pc_latch`  out  1  load PC with `pc_data`
- `pc_inc`  out  1  increment PC
- `pc_data`  out  8  PC load value (branch target)
- `mem_req`  out  1  instruction memory read request
- `mem_addr`  out  8  read address, equals `pc_value`
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  8  read data
- `instr_valid`  out  1  instruction available to decode
- `instr_ready`  in  1  decode accepts instruction
- `instr_opcode`  out  8  opcode byte
- `instr_operand`  out  8  operand byte; 0 for one-byte instructions
- `instr_long`  out  1  1 = two-byte instruction
- `instr_pc`  out  8  address of the opcode byte
- `branch_valid`  in  1  redirect request from execute
- `branch_target`  in  8  redirect address
- `stall`  in  1  hold off new fetches

## Operation
- FSM states:
  - `FETCH_OP`: issue a read for the opcode byte.
  - `FETCH_ARG`: issue a read for the operand byte.
  - `ISSUE`: present the instruction to decode.
- `FETCH_OP`:
  - `mem_req = !stall`; `mem_addr = pc_value`.
  - On `mem_req & mem_ack`: capture `instr_opcode = mem_rdata` and `instr_pc = pc_value`, pulse `pc_inc`.
  - Then go to `FETCH_ARG` if `mem_rdata[LONG_BIT]`. Otherwise clear `instr_operand` and `instr_long`, and go to `ISSUE`.
- `FETCH_ARG`:
  - `mem_req = 1` (`stall` ignored; the instruction is completed first).
  - On `mem_ack`: capture `instr_operand`, set `instr_long = 1`, pulse `pc_inc`, go to `ISSUE`.
- `ISSUE`:
  - `instr_valid = 1`.
  - The `instr_*` fields hold stable until `instr_valid & instr_ready`, then go to `FETCH_OP`.
- Branch (highest priority after reset, any state):
  - `pc_latch = 1`, `pc_data = branch_target`, `pc_inc = 0`.
  - `mem_req` and `instr_valid` are forced to 0 that cycle.
  - Any `mem_ack` or `instr_ready` in the same cycle is ignored, and partial instruction state is discarded.
  - Next state is `FETCH_OP`.
- `pc_latch` and `pc_inc` are never asserted together.
- `pc_data = branch_target` whenever `branch_valid`; otherwise 0.
- PC arithmetic is the register's mod-256 increment. Fetch wraps 0xFF→0x00 without special handling. A two-byte instruction at 0xFF takes its operand from 0x00.

## Timing
- Reset values:
  - State `FETCH_OP`.
  - `instr_opcode`, `instr_operand`, `instr_pc`, `instr_long` = 0.
  - All control outputs are 0 while `reset` is high.
- Reset mid-operation abandons the fetch. `mem_req` drops in the reset cycle.
- Signal styles:
  - `mem_req` and `instr_valid` are decoded from state (gated by `branch_valid`, `stall`, `reset`).
  - `pc_inc` and `pc_latch` are combinational from state and inputs.
  - `instr_*` data fields are registered.
- The PC register updates on the edge where `pc_inc` is high, so `pc_value` shows the next address one cycle later. `mem_addr` for `FETCH_ARG` is therefore already advanced.
- Memory may drop an ack mid-request. The requester may deassert `mem_req` without an ack (branch or reset only).
- With zero-wait memory (ack in request cycle) and decode always ready:
  - One-byte instruction: 2 cycles.
  - Two-byte instruction: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- The first `mem_req` is issued in the first cycle after `reset` deasserts.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {`FETCH_OP`, `FETCH_ARG`, `ISSUE`}.
  - Default `LONG_BIT` constant.
  - 8-bit address/data width constant.
- No sub-module. The program-counter register is instantiated beside this block in the parent, with `pc_latch`/`pc_inc`/`pc_data` wired to its `latch`/`inc`/`data` and its output wired back to `pc_value`.

## Test plan
- One-byte instructions: reset, PC=0x00, memory 0x00→0x12, 0x01→0x34, zero-wait, ready=1. Required response:
  - `instr_valid` with opcode 0x12, pc 0x00, `instr_long` 0.
  - Two cycles later, opcode 0x34, pc 0x01.
  - `pc_inc` pulses once per instruction.
- Two-byte instruction: memory 0x00→0x85, 0x01→0xAA, 2-cycle wait states. Required response:
  - opcode 0x85, operand 0xAA, `instr_long` 1, pc 0x00.
  - `pc_value` = 0x02 at issue.
  - Exactly two `pc_inc` pulses.
- Backpressure: `instr_ready` = 0 for 5 cycles. Required response: `instr_*` stable, no `mem_req`, no `pc_inc` until ready.
- Branch: assert `branch_valid`, target 0x40, in `FETCH_ARG` together with `mem_ack`. Required response:
  - `pc_latch` = 1, `pc_data` = 0x40, `pc_inc` = 0.
  - The operand is discarded.
  - Next `mem_addr` = 0x40, and no partial instruction is issued.
- Wrap: start at PC 0xFF with a long opcode. Required response: operand read from 0x00, `instr_pc` 0xFF, `pc_value` 0x01 after issue.
- Stall and reset:
  - `stall` in `FETCH_OP`: `mem_req` stays 0 until release.
  - Reset asserted while in `ISSUE`: `instr_valid` drops the same cycle, and all `instr_*` fields read 0 afterwards.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Widths and the default long-instruction marker bit live here.
package fetch_pkg;

  localparam int W = 8;
  localparam int LONG_BIT_DEF = 7;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between fetch, PC register, instruction memory,
// decode and execute. master = fetch side, slave = environment.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic [W-1:0] pc_value;
  logic         pc_latch;
  logic         pc_inc;
  logic [W-1:0] pc_data;

  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr_opcode;
  logic [W-1:0] instr_operand;
  logic         instr_long;
  logic [W-1:0] instr_pc;

  logic         branch_valid;
  logic [W-1:0] branch_target;
  logic         stall;

  modport master (
    input  pc_value, mem_ack, mem_rdata, instr_ready,
    input  branch_valid, branch_target, stall,
    output pc_latch, pc_inc, pc_data, mem_req, mem_addr,
    output instr_valid, instr_opcode, instr_operand,
    output instr_long, instr_pc
  );

  modport slave (
    output pc_value, mem_ack, mem_rdata, instr_ready,
    output branch_valid, branch_target, stall,
    input  pc_latch, pc_inc, pc_data, mem_req, mem_addr,
    input  instr_valid, instr_opcode, instr_operand,
    input  instr_long, instr_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch sequencer: reads 1/2-byte instructions, drives the PC
// register controls and hands complete instructions to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int LONG_BIT = LONG_BIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [W-1:0] r_opcode;
  logic [W-1:0] r_operand;
  logic [W-1:0] r_pc;
  logic         r_long;

  logic w_req;
  logic w_valid;
  logic w_inc;
  logic w_latch;
  logic w_cap_op;
  logic w_cap_arg;
  logic w_short;

  assign w_short = !bus.mem_rdata[LONG_BIT];

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH_OP;
    else       r_state <= w_next;
  end

  // Branch overrides every state; ack/ready that cycle are dropped.
  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_valid   = 1'b0;
    w_inc     = 1'b0;
    w_latch   = 1'b0;
    w_cap_op  = 1'b0;
    w_cap_arg = 1'b0;
    if (reset) begin
      w_next = FETCH_OP;
    end else if (bus.branch_valid) begin
      w_latch = 1'b1;
      w_next  = FETCH_OP;
    end else begin
      unique case (r_state)
        FETCH_OP: begin
          w_req = !bus.stall;
          if (!bus.stall && bus.mem_ack) begin
            w_inc    = 1'b1;
            w_cap_op = 1'b1;
            w_next   = w_short ? ISSUE : FETCH_ARG;
          end
        end
        FETCH_ARG: begin
          w_req = 1'b1;
          if (bus.mem_ack) begin
            w_inc     = 1'b1;
            w_cap_arg = 1'b1;
            w_next    = ISSUE;
          end
        end
        ISSUE: begin
          w_valid = 1'b1;
          if (bus.instr_ready) w_next = FETCH_OP;
        end
        default: w_next = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode  <= '0;
      r_operand <= '0;
      r_pc      <= '0;
      r_long    <= 1'b0;
    end else if (w_cap_op) begin
      r_opcode <= bus.mem_rdata;
      r_pc     <= bus.pc_value;
      if (w_short) begin
        r_operand <= '0;
        r_long    <= 1'b0;
      end
    end else if (w_cap_arg) begin
      r_operand <= bus.mem_rdata;
      r_long    <= 1'b1;
    end
  end

  assign bus.mem_req       = w_req;
  assign bus.mem_addr      = bus.pc_value;
  assign bus.pc_inc        = w_inc;
  assign bus.pc_latch      = w_latch;
  assign bus.pc_data       = bus.branch_valid ? bus.branch_target : '0;
  assign bus.instr_valid   = w_valid;
  assign bus.instr_opcode  = r_opcode;
  assign bus.instr_operand = r_operand;
  assign bus.instr_long    = r_long;
  assign bus.instr_pc      = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a PC register model and a
// wait-state instruction memory model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.LONG_BIT(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0] mem [256];
  logic [7:0] r_pc;
  int         waits;
  int         r_cnt;
  logic       both_seen;
  int         n_cmp;
  int         n_err;

  always @(posedge clk) begin
    if (reset)             r_pc <= 8'h00;
    else if (bus.pc_latch) r_pc <= bus.pc_data;
    else if (bus.pc_inc)   r_pc <= r_pc + 8'h01;
  end

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) r_cnt <= 0;
    else                             r_cnt <= r_cnt + 1;
  end

  assign bus.pc_value  = r_pc;
  assign bus.mem_ack   = bus.mem_req && (r_cnt >= waits);
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(negedge clk)
    if (bus.pc_latch && bus.pc_inc) both_seen <= 1'b1;

  typedef struct {
    logic [7:0] start;
    logic [7:0] op;
    logic [7:0] arg;
    int         wt;
    logic [7:0] e_op;
    logic [7:0] e_arg;
    logic       e_long;
    logic [7:0] e_ipc;
    logic [7:0] e_pcv;
    int         e_cyc;
    int         e_inc;
  } vec_t;

  vec_t tv [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Entered just after a posedge; returns at the negedge where
  // instr_valid is seen.
  task automatic run_to_valid(output int cyc, output int incs);
    cyc  = 0;
    incs = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.instr_valid) return;
      if (bus.pc_inc) incs++;
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("valid_timeout", 32'd1, 32'd0);
  endtask

  int cyc;
  int incs;
  logic [7:0] a1;

  initial begin
    n_cmp = 0;
    n_err = 0;
    both_seen = 1'b0;
    waits = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'h00;
    bus.stall         = 1'b0;

    tv[0] = '{8'h00, 8'h12, 8'h34, 0,
              8'h12, 8'h00, 1'b0, 8'h00, 8'h01, 1, 1};
    tv[1] = '{8'h00, 8'h85, 8'hAA, 2,
              8'h85, 8'hAA, 1'b1, 8'h00, 8'h02, 6, 2};
    tv[2] = '{8'hFF, 8'h90, 8'h5C, 0,
              8'h90, 8'h5C, 1'b1, 8'hFF, 8'h01, 2, 2};
    tv[3] = '{8'h10, 8'h7F, 8'h99, 1,
              8'h7F, 8'h00, 1'b0, 8'h10, 8'h11, 2, 1};

    @(negedge clk);
    chk("rst_ctrl", {bus.mem_req, bus.instr_valid,
        bus.pc_inc, bus.pc_latch}, 4'b0000);
    chk("rst_fields", {bus.instr_opcode, bus.instr_operand,
        bus.instr_pc, 7'd0, bus.instr_long}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      waits = tv[v].wt;
      a1 = tv[v].start + 8'h01;
      mem[tv[v].start] = tv[v].op;
      mem[a1] = tv[v].arg;
      do_reset();
      bus.branch_valid  = 1'b1;
      bus.branch_target = tv[v].start;
      @(posedge clk);
      #1;
      bus.branch_valid = 1'b0;
      run_to_valid(cyc, incs);
      chk($sformatf("v%0d_op", v), bus.instr_opcode, tv[v].e_op);
      chk($sformatf("v%0d_arg", v), bus.instr_operand, tv[v].e_arg);
      chk($sformatf("v%0d_long", v), bus.instr_long, tv[v].e_long);
      chk($sformatf("v%0d_ipc", v), bus.instr_pc, tv[v].e_ipc);
      chk($sformatf("v%0d_pcv", v), bus.pc_value, tv[v].e_pcv);
      chk($sformatf("v%0d_cyc", v), cyc, tv[v].e_cyc);
      chk($sformatf("v%0d_inc", v), incs, tv[v].e_inc);
      @(posedge clk);
      #1;
    end

    // Back-to-back one-byte instructions, zero wait.
    waits = 0;
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h34;
    do_reset();
    @(negedge clk);
    chk("first_req", {bus.mem_req, bus.pc_inc, bus.mem_addr},
        {1'b1, 1'b1, 8'h00});
    @(posedge clk);
    #1;
    run_to_valid(cyc, incs);
    chk("b2b_0", {cyc[7:0], bus.instr_opcode, bus.instr_pc},
        {8'd0, 8'h12, 8'h00});
    @(posedge clk);
    #1;
    run_to_valid(cyc, incs);
    chk("b2b_1", {cyc[7:0], bus.instr_opcode, bus.instr_pc},
        {8'd1, 8'h34, 8'h01});
    chk("b2b_inc", incs, 1);

    // Backpressure.
    do_reset();
    bus.instr_ready = 1'b0;
    run_to_valid(cyc, incs);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {bus.instr_valid,
          bus.mem_req, bus.pc_inc, bus.instr_opcode},
          {1'b1, 1'b0, 1'b0, 8'h12});
    end
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", bus.instr_valid, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next_req", {bus.mem_req, bus.mem_addr},
        {1'b1, 8'h01});

    // Branch in FETCH_ARG coinciding with the operand ack.
    mem[8'h00] = 8'h85;
    mem[8'h01] = 8'hAA;
    mem[8'h40] = 8'h05;
    do_reset();
    @(posedge clk);
    #1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h40;
    @(negedge clk);
    chk("br_ctrl", {bus.pc_latch, bus.pc_inc, bus.mem_req,
        bus.instr_valid, bus.pc_data}, {4'b1000, 8'h40});
    @(posedge clk);
    #1;
    bus.branch_valid = 1'b0;
    @(negedge clk);
    chk("br_after", {bus.mem_req, bus.instr_valid, bus.mem_addr},
        {2'b10, 8'h40});
    @(posedge clk);
    #1;
    run_to_valid(cyc, incs);
    chk("br_instr", {cyc[7:0], bus.instr_opcode, bus.instr_pc,
        bus.instr_operand}, {8'd0, 8'h05, 8'h40, 8'h00});
    chk("br_long", bus.instr_long, 1'b0);

    // Stall in FETCH_OP.
    bus.stall = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", i), {bus.mem_req, bus.pc_inc,
          bus.pc_value}, {2'b00, 8'h00});
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    @(negedge clk);
    chk("stall_rel", bus.mem_req, 1'b1);

    // Reset while in ISSUE.
    mem[8'h00] = 8'h12;
    do_reset();
    bus.instr_ready = 1'b0;
    run_to_valid(cyc, incs);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_issue", {bus.instr_valid, bus.mem_req, bus.pc_inc,
        bus.pc_latch}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("rst_clear", {bus.instr_opcode, bus.instr_operand,
        bus.instr_pc, 7'd0, bus.instr_long}, 32'd0);

    chk("latch_inc_excl", both_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
